alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Parametrised successor to the single-shot ALU control FSM.
- Accepts opcodes through a valid/ready command queue of DEPTH entries, so back-to-back operations need no idle handshaking.
- For each command, sequences LOAD -> EXECUTE -> STORE and drives a one-hot start vector over NUM_OPS functional units.
- Flags illegal opcodes; optionally aborts hung operations with a watchdog.

Parameters:
- OPW, 3, opcode width in bits.
- NUM_OPS, 7, number of functional units; opcodes 0..NUM_OPS-1 are legal; NUM_OPS <= 2**OPW.
- DEPTH, 4, command queue depth; power of two, >= 2.
- TIMEOUT_CYCLES, 64, watchdog limit in EXECUTE cycles; used only with ALU_SEQ_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present on cmd_opcode.
- cmd_opcode  in  OPW  operation code.
- cmd_ready  out  1  queue can accept a command; equals !full.
- op_done  in  1  selected unit has finished.
- load_a  out  1  operand A register load.
- load_b  out  1  operand B register load.
- load_out  out  1  result register load.
- start_op  out  NUM_OPS  one-hot unit start.
- sel_op  out  OPW  result mux select; holds the opcode in service.
- done  out  1  registered one-cycle pulse per completed command.
- err_illegal  out  1  registered one-cycle pulse per illegal opcode.
- busy  out  1  high when not IDLE or queue not empty.
- q_level  out  $clog2(DEPTH)+1  queue occupancy.
- timeout_err  out  1  one-cycle pulse on watchdog abort; present only with ALU_SEQ_TIMEOUT_EN.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE; queue empty; q_level=0; cmd_ready=1.
  - All pulse outputs, load_*, start_op and busy are 0; sel_op=0.
  - An operation in flight is dropped with no done.
- Queue:
  - Push when cmd_valid & cmd_ready. Pop only in IDLE when non-empty.
  - Push and pop in the same cycle are both honoured; q_level is unchanged.
  - Full: cmd_ready=0 and no push occurs.
  - Pointers wrap modulo DEPTH.
- FSM, with the opcode in service latched at pop into op_q:
  - IDLE: if the queue is non-empty, pop and go to LOAD if op_q is legal, else to FAULT.
  - LOAD: load_a=load_b=1 for exactly one cycle -> EXECUTE.
  - EXECUTE:
    - start_op[op_q] is asserted for the first EXECUTE cycle only (one-cycle pulse).
    - op_done is sampled every EXECUTE cycle, including the first.
    - op_done=1 -> STORE.
  - STORE: load_out=1 for one cycle -> IDLE. done pulses on the following cycle.
  - FAULT: no load or start outputs -> IDLE. err_illegal pulses on the following cycle.
- sel_op = op_q in every state; it holds the last value in IDLE.
- op_done is ignored outside EXECUTE.
- Minimum per-command latency, cmd accept to done: 5 cycles (push, IDLE/pop, LOAD, EXECUTE with op_done=1, STORE, then done registered).
- Back-to-back throughput: 1 command per 4 cycles when op_done returns in the first EXECUTE cycle.
- busy = (state!=IDLE) | (q_level!=0).

Optional Feature:
- Macro: ALU_SEQ_TIMEOUT_EN.
- Defined:
  - A counter clears on EXECUTE entry and increments each EXECUTE cycle.
  - If TIMEOUT_CYCLES cycles elapse without op_done, the FSM goes to IDLE with no load_out and no done.
  - timeout_err pulses on the following cycle.
  - op_done arriving in the same cycle as expiry wins: the normal STORE path is taken.
- Undefined:
  - The timeout_err port and the counter do not exist.
  - EXECUTE waits indefinitely for op_done.

Decomposition:
- Package alu_seq_pkg holds:
  - state encoding localparams IDLE, LOAD, EXECUTE, STORE, FAULT (3-bit);
  - default opcode constants OP_ADD=0 .. OP_XOR=6.
- One sub-module, alu_cmd_fifo, is parametrised by width OPW and depth DEPTH:
  - ports: push, pop, din, dout, full, empty, level;
  - output is registered and first-word-fall-through.

Test Plan:
- Single add: push opcode 0, op_done returned 2 cycles after start -> load_a/load_b 1 cycle, start_op=7'b0000001 for 1 cycle, load_out then done; sel_op=0.
- Burst: push 4 commands (2,3,4,5) back-to-back, op_done returned immediately -> cmd_ready stays 1, q_level peaks at 3, four done pulses spaced 4 cycles apart, start_op order 0x04, 0x08, 0x10, 0x20.
- Full queue: stall op_done, push 5 commands -> 5th accepted only after the first pop; cmd_ready=0 while q_level=4.
- Illegal opcode 7 with NUM_OPS=7 -> no load_a/start_op/load_out, err_illegal one pulse, no done; the next queued opcode 1 executes normally.
- Reset mid-EXECUTE: assert reset_n=0 asynchronously with 2 entries queued -> all outputs 0 immediately, q_level=0, no done after release.
- With ALU_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=8, op_done held 0 -> timeout_err pulses after 8 EXECUTE cycles, no done; a second run with op_done in cycle 8 gives done and no timeout_err.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU command sequencer: FSM state codes and default opcodes.
package alu_seq_pkg;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOAD    = 3'd1;
  localparam logic [2:0] EXECUTE = 3'd2;
  localparam logic [2:0] STORE   = 3'd3;
  localparam logic [2:0] FAULT   = 3'd4;

  typedef enum logic [2:0] {
    StIdle    = IDLE,
    StLoad    = LOAD,
    StExecute = EXECUTE,
    StStore   = STORE,
    StFault   = FAULT
  } state_e;

  localparam int unsigned OP_ADD = 0;
  localparam int unsigned OP_SUB = 1;
  localparam int unsigned OP_AND = 2;
  localparam int unsigned OP_OR  = 3;
  localparam int unsigned OP_SLT = 4;
  localparam int unsigned OP_SLL = 5;
  localparam int unsigned OP_XOR = 6;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Flop-based first-word-fall-through command queue; dout always shows the head entry.
module alu_cmd_fifo #(
  parameter int unsigned Width = 3,
  parameter int unsigned Depth = 4,
  localparam int unsigned Aw   = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [Aw:0]      level
);

  logic [Width-1:0] mem_q [Depth];
  logic [Aw-1:0]    wr_ptr_q, rd_ptr_q;
  logic [Aw:0]      level_q;
  logic             do_push, do_pop;

  assign full    = (level_q == (Aw+1)'(Depth));
  assign empty   = (level_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];
  assign level   = level_q;

  // Pointers are exactly Aw bits wide, so they wrap modulo Depth on their own.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      level_q <= level_q + 1'b1;
      else if (do_pop && !do_push) level_q <= level_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/alu_sequencer.sv
// Queued ALU control sequencer: LOAD -> EXECUTE -> STORE per command, illegal-opcode fault path.
// Optional EXECUTE watchdog enabled by defining ALU_SEQ_TIMEOUT_EN.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned OPW            = 3,
  parameter int unsigned NUM_OPS        = 7,
  parameter int unsigned DEPTH          = 4,
`ifdef ALU_SEQ_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES = 64,
`endif
  localparam int unsigned Lw            = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cmd_valid,
  input  logic [OPW-1:0]     cmd_opcode,
  output logic               cmd_ready,
  input  logic               op_done,
  output logic               load_a,
  output logic               load_b,
  output logic               load_out,
  output logic [NUM_OPS-1:0] start_op,
  output logic [OPW-1:0]     sel_op,
  output logic               done,
  output logic               err_illegal,
  output logic               busy,
  output logic [Lw-1:0]      q_level
`ifdef ALU_SEQ_TIMEOUT_EN
  ,
  output logic               timeout_err
`endif
);

  state_e         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic           first_q, done_q, err_q;
  logic           fifo_full, fifo_empty, fifo_pop;
  logic [OPW-1:0] fifo_dout;
  logic           head_legal;

  alu_cmd_fifo #(
    .Width (OPW),
    .Depth (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (cmd_valid & ~fifo_full),
    .pop     (fifo_pop),
    .din     (cmd_opcode),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (q_level)
  );

  assign fifo_pop   = (state_q == StIdle) & ~fifo_empty;
  assign head_legal = ({1'b0, fifo_dout} < (OPW+1)'(NUM_OPS));
  assign cmd_ready  = ~fifo_full;
  assign busy       = (state_q != StIdle) | (q_level != '0);
  assign sel_op     = op_q;
  assign done       = done_q;
  assign err_illegal = err_q;

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int unsigned Tw = $clog2(TIMEOUT_CYCLES + 1);
  logic [Tw-1:0] tmo_cnt_q;
  logic          tmo_fire, tmo_err_q;

  // Counter holds the number of EXECUTE cycles already completed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_err_q <= tmo_fire;
      if (state_q == StLoad)         tmo_cnt_q <= '0;
      else if (state_q == StExecute) tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  assign timeout_err = tmo_err_q;
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    load_a   = 1'b0;
    load_b   = 1'b0;
    load_out = 1'b0;
    start_op = '0;
`ifdef ALU_SEQ_TIMEOUT_EN
    tmo_fire = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          op_d    = fifo_dout;
          state_d = head_legal ? StLoad : StFault;
        end
      end
      StLoad: begin
        load_a  = 1'b1;
        load_b  = 1'b1;
        state_d = StExecute;
      end
      StExecute: begin
        for (int unsigned i = 0; i < NUM_OPS; i++) begin
          start_op[i] = first_q && (op_q == OPW'(i));
        end
        if (op_done) begin
          state_d = StStore;
`ifdef ALU_SEQ_TIMEOUT_EN
        end else if (tmo_cnt_q == Tw'(TIMEOUT_CYCLES - 1)) begin
          state_d  = StIdle;
          tmo_fire = 1'b1;
`endif
        end
      end
      StStore: begin
        load_out = 1'b1;
        state_d  = StIdle;
      end
      StFault: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      op_q    <= '0;
      first_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      first_q <= (state_q == StLoad);
      done_q  <= (state_q == StStore);
      err_q   <= (state_q == StFault);
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer; timeout scenario included when ALU_SEQ_TIMEOUT_EN is defined.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd_opcode = 3'd0;
  logic       cmd_ready;
  logic       op_done = 1'b0;
  logic       load_a, load_b, load_out;
  logic [6:0] start_op;
  logic [2:0] sel_op;
  logic       done, err_illegal, busy;
  logic [2:0] q_level;
`ifdef ALU_SEQ_TIMEOUT_EN
  logic       timeout_err;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [2:0] exp_done[$], obs_done[$], exp_err[$], obs_err[$];
  logic [6:0] exp_start[$], obs_start[$];
  int done_cyc[$];
  int n_load_a, n_load_b, n_load_out, max_level, start_cyc, tmo_cyc, n_tmo;

  int resp_delay = 0;
  int rcnt = -1;
  logic force_done = 1'b0;

  alu_sequencer #(
    .OPW            (3),
    .NUM_OPS        (7),
`ifdef ALU_SEQ_TIMEOUT_EN
    .TIMEOUT_CYCLES (8),
`endif
    .DEPTH          (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_opcode  (cmd_opcode),
    .cmd_ready   (cmd_ready),
    .op_done     (op_done),
    .load_a      (load_a),
    .load_b      (load_b),
    .load_out    (load_out),
    .start_op    (start_op),
    .sel_op      (sel_op),
    .done        (done),
    .err_illegal (err_illegal),
    .busy        (busy),
`ifdef ALU_SEQ_TIMEOUT_EN
    .timeout_err (timeout_err),
`endif
    .q_level     (q_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Functional-unit model: answers resp_delay cycles after the start pulse (-1 = never).
  always @(negedge clk) begin
    if (start_op != '0) rcnt = resp_delay;
    else if (rcnt > 0) rcnt = rcnt - 1;
    else rcnt = -1;
    op_done = (rcnt == 0) || force_done;
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (start_op != '0) begin obs_start.push_back(start_op); start_cyc = cyc; end
      if (done) begin obs_done.push_back(sel_op); done_cyc.push_back(cyc); end
      if (err_illegal) obs_err.push_back(sel_op);
      if (load_a) n_load_a++;
      if (load_b) n_load_b++;
      if (load_out) n_load_out++;
      if (int'(q_level) > max_level) max_level = int'(q_level);
`ifdef ALU_SEQ_TIMEOUT_EN
      if (timeout_err) begin n_tmo++; tmo_cyc = cyc; end
`endif
    end
  end

  task automatic clear_obs();
    exp_done.delete(); obs_done.delete(); exp_err.delete(); obs_err.delete();
    exp_start.delete(); obs_start.delete(); done_cyc.delete();
    n_load_a = 0; n_load_b = 0; n_load_out = 0; max_level = 0; n_tmo = 0;
    start_cyc = 0; tmo_cyc = 0;
  endtask

  // Present one command and hold it until accepted; records expectations at acceptance.
  task automatic push_cmd(input logic [2:0] op, output int waited, output int acc_cyc);
    waited = 0;
    cmd_valid = 1'b1;
    cmd_opcode = op;
    @(negedge clk);
    while (!cmd_ready && waited < 200) begin waited++; @(negedge clk); end
    acc_cyc = cyc;
    total++;
    if (!cmd_ready) begin
      bad++;
      $display("FAIL push_accept op=%0d got ready=0 want ready=1 within 200 cycles", op);
    end else if (op < 3'd7) begin
      exp_done.push_back(op);
      exp_start.push_back(7'd1 << op);
    end else begin
      exp_err.push_back(op);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    int n = 0;
    @(negedge clk);
    while (busy && n < limit) begin n++; @(negedge clk); end
    ok = !busy;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    total++; if (q_level !== 3'd0) begin bad++; $display("FAIL rst_level got=%0d want=0", q_level); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", cmd_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++;
    if ({load_a, load_b, load_out, start_op, sel_op, done, err_illegal} !== 15'd0) begin
      bad++;
      $display("FAIL rst_outputs got=%b/%b/%b/%h/%0d/%b/%b want all 0",
               load_a, load_b, load_out, start_op, sel_op, done, err_illegal);
    end
  endtask

  task automatic test_single_add();
    int w, acc; bit ok;
    clear_obs();
    resp_delay = 2;
    push_cmd(3'd0, w, acc);
    wait_idle(100, ok);
    total++; if (!ok) begin bad++; $display("FAIL add_idle got busy want idle"); end
    total++; if (obs_start.size() != 1) begin bad++; $display("FAIL add_start_cnt got=%0d want=1", obs_start.size()); end
    while (exp_start.size() > 0 && obs_start.size() > 0) begin
      logic [6:0] e, o; e = exp_start.pop_front(); o = obs_start.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL add_start got=%b want=%b", o, e); end
    end
    total++;
    if (n_load_a != 1 || n_load_b != 1 || n_load_out != 1) begin
      bad++; $display("FAIL add_loads got a=%0d b=%0d out=%0d want 1/1/1", n_load_a, n_load_b, n_load_out);
    end
    total++; if (obs_done.size() != 1) begin bad++; $display("FAIL add_done_cnt got=%0d want=1", obs_done.size()); end
    while (exp_done.size() > 0 && obs_done.size() > 0) begin
      logic [2:0] e, o; e = exp_done.pop_front(); o = obs_done.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL add_sel got=%0d want=%0d", o, e); end
    end
    if (done_cyc.size() > 0) begin
      total++;
      if (done_cyc[0] - acc != 7) begin
        bad++; $display("FAIL add_latency got=%0d want=7", done_cyc[0] - acc);
      end
    end
  endtask

  task automatic test_burst();
    int w, acc, wsum; bit ok;
    clear_obs();
    resp_delay = 0;
    wsum = 0;
    for (int i = 2; i <= 5; i++) begin push_cmd(3'(i), w, acc); wsum += w; end
    wait_idle(100, ok);
    total++; if (wsum != 0) begin bad++; $display("FAIL burst_ready got waits=%0d want=0", wsum); end
    total++; if (max_level != 3) begin bad++; $display("FAIL burst_peak got=%0d want=3", max_level); end
    total++; if (obs_done.size() != 4) begin bad++; $display("FAIL burst_done_cnt got=%0d want=4", obs_done.size()); end
    for (int i = 1; i < done_cyc.size(); i++) begin
      total++;
      if (done_cyc[i] - done_cyc[i-1] != 4) begin
        bad++; $display("FAIL burst_spacing got=%0d want=4", done_cyc[i] - done_cyc[i-1]);
      end
    end
    while (exp_start.size() > 0 && obs_start.size() > 0) begin
      logic [6:0] e, o; e = exp_start.pop_front(); o = obs_start.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL burst_start got=%h want=%h", o, e); end
    end
    while (exp_done.size() > 0 && obs_done.size() > 0) begin
      logic [2:0] e, o; e = exp_done.pop_front(); o = obs_done.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL burst_sel got=%0d want=%0d", o, e); end
    end
  endtask

  task automatic test_full_queue();
    int w, acc; bit ok;
    clear_obs();
    resp_delay = -1;
    for (int i = 1; i <= 5; i++) push_cmd(3'(i), w, acc);
    cmd_valid = 1'b1;
    cmd_opcode = 3'd6;
    repeat (5) @(negedge clk);
    total++; if (q_level !== 3'd4) begin bad++; $display("FAIL full_level got=%0d want=4", q_level); end
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b want=0", cmd_ready); end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    resp_delay = 0;
    force_done = 1'b1;
    @(posedge clk); #1;
    force_done = 1'b0;
    push_cmd(3'd6, w, acc);
    total++; if (w == 0) begin bad++; $display("FAIL full_stall got waits=0 want >0"); end
    wait_idle(200, ok);
    total++; if (obs_done.size() != 6) begin bad++; $display("FAIL full_done_cnt got=%0d want=6", obs_done.size()); end
    while (exp_done.size() > 0 && obs_done.size() > 0) begin
      logic [2:0] e, o; e = exp_done.pop_front(); o = obs_done.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL full_order got=%0d want=%0d", o, e); end
    end
  endtask

  task automatic test_illegal();
    int w, acc; bit ok;
    clear_obs();
    resp_delay = 0;
    push_cmd(3'd7, w, acc);
    push_cmd(3'd1, w, acc);
    wait_idle(100, ok);
    total++; if (obs_err.size() != 1) begin bad++; $display("FAIL ill_err_cnt got=%0d want=1", obs_err.size()); end
    while (exp_err.size() > 0 && obs_err.size() > 0) begin
      logic [2:0] e, o; e = exp_err.pop_front(); o = obs_err.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL ill_err_op got=%0d want=%0d", o, e); end
    end
    total++;
    if (n_load_a != 1 || n_load_out != 1 || obs_start.size() != 1) begin
      bad++; $display("FAIL ill_no_exec got a=%0d out=%0d starts=%0d want 1/1/1",
                      n_load_a, n_load_out, obs_start.size());
    end
    total++; if (obs_done.size() != 1) begin bad++; $display("FAIL ill_done_cnt got=%0d want=1", obs_done.size()); end
    while (exp_start.size() > 0 && obs_start.size() > 0) begin
      logic [6:0] e, o; e = exp_start.pop_front(); o = obs_start.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL ill_next_start got=%b want=%b", o, e); end
    end
  endtask

  task automatic test_reset_mid();
    int w, acc;
    clear_obs();
    resp_delay = -1;
    for (int i = 3; i <= 5; i++) push_cmd(3'(i), w, acc);
    repeat (3) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if ({load_a, load_b, load_out, start_op, done, err_illegal, busy} !== 13'd0) begin
      bad++; $display("FAIL mid_outputs got=%b/%b/%b/%h/%b/%b/%b want all 0",
                      load_a, load_b, load_out, start_op, done, err_illegal, busy);
    end
    total++; if (q_level !== 3'd0) begin bad++; $display("FAIL mid_level got=%0d want=0", q_level); end
    total++; if (sel_op !== 3'd0) begin bad++; $display("FAIL mid_sel got=%0d want=0", sel_op); end
    @(negedge clk);
    reset_n = 1'b1;
    clear_obs();
    resp_delay = 0;
    repeat (20) @(negedge clk);
    total++;
    if (obs_done.size() != 0 || obs_start.size() != 0) begin
      bad++; $display("FAIL mid_dropped got done=%0d starts=%0d want 0/0", obs_done.size(), obs_start.size());
    end
    @(posedge clk); #1;
  endtask

`ifdef ALU_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int w, acc; bit ok;
    clear_obs();
    resp_delay = -1;
    push_cmd(3'd2, w, acc);
    wait_idle(100, ok);
    total++; if (!ok) begin bad++; $display("FAIL tmo_idle got busy want idle"); end
    total++; if (n_tmo != 1) begin bad++; $display("FAIL tmo_pulses got=%0d want=1", n_tmo); end
    total++; if (tmo_cyc - start_cyc != 8) begin bad++; $display("FAIL tmo_when got=%0d want=8", tmo_cyc - start_cyc); end
    total++;
    if (obs_done.size() != 0 || n_load_out != 0) begin
      bad++; $display("FAIL tmo_nodone got done=%0d out=%0d want 0/0", obs_done.size(), n_load_out);
    end
    clear_obs();
    resp_delay = 7;
    push_cmd(3'd3, w, acc);
    wait_idle(100, ok);
    total++; if (n_tmo != 0) begin bad++; $display("FAIL tmo_race got=%0d want=0", n_tmo); end
    total++; if (obs_done.size() != 1) begin bad++; $display("FAIL tmo_race_done got=%0d want=1", obs_done.size()); end
  endtask
`endif

  initial begin
    clear_obs();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_single_add();
    test_burst();
    test_full_queue();
    test_illegal();
    test_reset_mid();
`ifdef ALU_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
